centroid_div_sequencer: RTL

Time-multiplexes one iterative unsigned divider across N independent dividend/divisor pairs (per-colour coordinate sums and pixel counts), replacing N parallel dividers in the object-recognition path. It sits between the per-frame accumulators and the corner-smoothing and side-length logic. On `start` it snapshots all operands, divides them in fixed channel order, and publishes all quotients together with a one-cycle `valid` pulse.

---
 rtl/augreal_pkg.sv | 25 ++
 rtl/centroid_div_sequencer_if.sv | 26 ++
 rtl/serial_divider.sv | 63 ++++++
 rtl/centroid_div_sequencer.sv | 119 +++++++++++
 4 files changed

// File: rtl/augreal_pkg.sv
// Shared object-recognition definitions: sequencer states, default sizes and
// the per-colour x/y channel ordering used on the packed operand buses.
package augreal_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    STORE,
    DONE
  } seq_state_e;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_N     = 8;

  localparam int unsigned CH_X0 = 0;
  localparam int unsigned CH_Y0 = 1;
  localparam int unsigned CH_X1 = 2;
  localparam int unsigned CH_Y1 = 3;
  localparam int unsigned CH_X2 = 4;
  localparam int unsigned CH_Y2 = 5;
  localparam int unsigned CH_X3 = 6;
  localparam int unsigned CH_Y3 = 7;

endpackage

// File: rtl/centroid_div_sequencer_if.sv
// Request/result bundle between the frame accumulators and the divider sequencer.
interface centroid_div_sequencer_if
  import augreal_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned N     = DEF_N
);
  logic                 start;
  logic                 abort;
  logic [N*WIDTH-1:0]   dividend;
  logic [N*WIDTH-1:0]   divisor;
  logic                 busy;
  logic [N*WIDTH-1:0]   quotient;
  logic [N-1:0]         div_by_zero;
  logic                 valid;

  modport master (
    output start, abort, dividend, divisor,
    input  busy, quotient, div_by_zero, valid
  );

  modport slave (
    input  start, abort, dividend, divisor,
    output busy, quotient, div_by_zero, valid
  );
endinterface

// File: rtl/serial_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; done pulses WIDTH
// cycles after start. Divide by zero yields all-ones.
module serial_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             done
);
  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q;

  // Returns {remainder, shifted quotient} after one restoring step.
  function automatic logic [2*WIDTH-1:0] step(input logic [WIDTH-1:0] rem,
                                              input logic [WIDTH-1:0] quo,
                                              input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0] trial;
    logic           qbit;
    trial = {rem, quo[WIDTH-1]};
    qbit  = (trial >= {1'b0, dvs});
    if (qbit) trial = trial - {1'b0, dvs};
    return {trial[WIDTH-1:0], quo[WIDTH-2:0], qbit};
  endfunction

  // First step is taken on the start edge so the result and done coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        {rem_q, quo_q} <= step('0, dividend, divisor);
        dvs_q          <= divisor;
        cnt_q          <= CW'(WIDTH - 1);
        busy_q         <= (WIDTH > 1);
        done_q         <= (WIDTH == 1);
      end else if (busy_q) begin
        {rem_q, quo_q} <= step(rem_q, quo_q, dvs_q);
        cnt_q          <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q;
  assign done     = done_q;

endmodule

// File: rtl/centroid_div_sequencer.sv
// Shares one serial divider across N snapshotted dividend/divisor channels and
// publishes all quotients together with a one-cycle valid pulse.
module centroid_div_sequencer
  import augreal_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned N     = DEF_N
) (
  input  logic                     clk,
  input  logic                     reset,
  centroid_div_sequencer_if.slave  bus
);
  localparam int unsigned      IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0]  LAST = IDXW'(N - 1);

  seq_state_e          state_q, state_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [N*WIDTH-1:0]  snap_dvd_q, snap_dvs_q, stage_q, stage_d, quot_q;
  logic [N-1:0]        stage_dbz_q, stage_dbz_d, dbz_q;
  logic [WIDTH-1:0]    cur_dvd, cur_dvs, div_q;
  logic                div_done, div_start, store_en, fsm_busy, fsm_valid, publish;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q != IDLE && bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (bus.start) begin
                 state_d = LOAD;
                 idx_d   = '0;
               end
        LOAD:  state_d = RUN;
        RUN:   if (div_done) state_d = STORE;
        STORE: if (idx_q == LAST) state_d = DONE;
               else begin
                 idx_d   = idx_q + 1'b1;
                 state_d = LOAD;
               end
        DONE:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    fsm_busy  = (state_q != IDLE);
    fsm_valid = (state_q == DONE);
    div_start = (state_q == LOAD);
    store_en  = (state_q == STORE);
  end

  assign cur_dvd = snap_dvd_q[idx_q*WIDTH +: WIDTH];
  assign cur_dvs = snap_dvs_q[idx_q*WIDTH +: WIDTH];

  serial_divider #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (cur_dvd),
    .divisor  (cur_dvs),
    .quotient (div_q),
    .done     (div_done)
  );

  always_comb begin
    stage_d     = stage_q;
    stage_dbz_d = stage_dbz_q;
    if (store_en) begin
      stage_d[idx_q*WIDTH +: WIDTH] = (cur_dvs == '0) ? '0 : div_q;
      stage_dbz_d[idx_q]            = (cur_dvs == '0);
    end
  end

  // Outputs load on the edge into DONE, from the staging value including the
  // last channel, so quotient changes in the same cycle valid is high.
  assign publish = store_en && (idx_q == LAST) && !bus.abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      snap_dvd_q  <= '0;
      snap_dvs_q  <= '0;
      stage_q     <= '0;
      stage_dbz_q <= '0;
      quot_q      <= '0;
      dbz_q       <= '0;
    end else begin
      if (state_q == IDLE && bus.start) begin
        snap_dvd_q <= bus.dividend;
        snap_dvs_q <= bus.divisor;
      end
      if (store_en && !bus.abort) begin
        stage_q     <= stage_d;
        stage_dbz_q <= stage_dbz_d;
      end
      if (publish) begin
        quot_q <= stage_d;
        dbz_q  <= stage_dbz_d;
      end
    end
  end

  assign bus.busy        = fsm_busy;
  assign bus.valid       = fsm_valid;
  assign bus.quotient    = quot_q;
  assign bus.div_by_zero = dbz_q;

endmodule
